// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch/issue sequencer: PC selector codes,
// sequencer state encoding and the issue-time priority resolver.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        PC_NEXT = 2'd0,
        PC_KEEP = 2'd1,
        PC_LOAD = 2'd2
    } pc_sel_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_HALTED = 2'd3
    } seq_state_t;

    typedef enum logic [2:0] {
        ACT_SEQ       = 3'd0,
        ACT_BRANCH    = 3'd1,
        ACT_PUSH      = 3'd2,
        ACT_OVERFLOW  = 3'd3,
        ACT_POP       = 3'd4,
        ACT_UNDERFLOW = 3'd5,
        ACT_HALT      = 3'd6
    } issue_act_t;

    // Priority halt > ret > call > branch > sequential; stack state picks the error variants.
    function automatic issue_act_t resolve_issue(
        input logic halt,
        input logic ret,
        input logic call,
        input logic branch_taken,
        input logic stack_empty,
        input logic stack_full
    );
        issue_act_t act;
        if (halt)              act = ACT_HALT;
        else if (ret)          act = stack_empty ? ACT_UNDERFLOW : ACT_POP;
        else if (call)         act = stack_full ? ACT_OVERFLOW : ACT_PUSH;
        else if (branch_taken) act = ACT_BRANCH;
        else                   act = ACT_SEQ;
        return act;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch and decoder issue signals of the sequencer.
interface pc_sequencer_if #(
    parameter int WORD_SIZE  = 15,
    parameter int DATA_WIDTH = 16
);
    // Handshakes: a transfer happens on a rising edge where the requester's
    // signal (mem_req / instr_valid) and the responder's signal (mem_ack /
    // instr_ready) are both high; the requester holds its side stable until then.
    // Decoder control inputs are only meaningful in the instr_ready cycle.
    logic                  mem_req;
    logic [WORD_SIZE-1:0]  mem_addr;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_data;

    logic                  instr_valid;
    logic [DATA_WIDTH-1:0] instr_data;
    logic                  instr_ready;
    logic                  branch_taken;
    logic [WORD_SIZE-1:0]  branch_target;
    logic                  call;
    logic                  ret;
    logic                  halt;

    modport master (
        output mem_req, mem_addr, instr_valid, instr_data,
        input  mem_ack, mem_data, instr_ready, branch_taken, branch_target,
               call, ret, halt
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr_data,
        output mem_ack, mem_data, instr_ready, branch_taken, branch_target,
               call, ret, halt
    );

endinterface

// File: rtl/pc_sequencer_return_address_stack.sv
// LIFO of return addresses for call/ret; push and pop are ignored when full/empty.
module return_address_stack #(
    parameter int WORD_SIZE   = 15,
    parameter int STACK_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WORD_SIZE-1:0] push_data,
    output logic [WORD_SIZE-1:0] top,
    output logic                 full,
    output logic                 empty
);

    localparam int PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);

    logic [WORD_SIZE-1:0] entries [STACK_DEPTH];
    logic [CNT_W-1:0]     count;
    logic [PTR_W-1:0]     top_ptr;

    assign full    = (count == CNT_W'(STACK_DEPTH));
    assign empty   = (count == '0);
    assign top_ptr = PTR_W'(count - CNT_W'(1));
    assign top     = empty ? '0 : entries[top_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (push && !full) begin
            entries[count[PTR_W-1:0]] <= push_data;
            count                     <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/issue controller: fetches at the current PC, hands the word to the
// decoder, then steers the ProgramCounter according to the decoder's request.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int WORD_SIZE   = 15,
    parameter int DATA_WIDTH  = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] pc_value,
    output logic [1:0]           pc_selector,
    output logic [WORD_SIZE-1:0] pc_load_value,
    pc_sequencer_if.master       bus,
    output logic                 halted,
    output logic                 stack_overflow,
    output logic                 stack_underflow,
    output seq_state_t           dbg_state
);

    seq_state_t            state, next_state;
    logic [DATA_WIDTH-1:0] instr_q;
    issue_act_t            act;

    pc_sel_t               sel_c;
    logic [WORD_SIZE-1:0]  load_c;
    logic                  mem_req_c;
    logic                  valid_c;
    logic                  halted_c;
    logic                  latch_c;
    logic                  push_c;
    logic                  pop_c;
    logic                  set_ovf_c;
    logic                  set_unf_c;

    logic [WORD_SIZE-1:0]  ret_addr;
    logic [WORD_SIZE-1:0]  stack_top;
    logic                  stack_full;
    logic                  stack_empty;

    // Wraps naturally: a call from the last address returns to 0.
    assign ret_addr = pc_value + WORD_SIZE'(1);

    return_address_stack #(
        .WORD_SIZE   (WORD_SIZE),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (push_c),
        .pop       (pop_c),
        .push_data (ret_addr),
        .top       (stack_top),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    assign act = resolve_issue(bus.halt, bus.ret, bus.call, bus.branch_taken,
                               stack_empty, stack_full);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            instr_q         <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            state <= next_state;
            if (latch_c)   instr_q         <= bus.mem_data;
            if (set_ovf_c) stack_overflow  <= 1'b1;
            if (set_unf_c) stack_underflow <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        sel_c      = PC_KEEP;
        load_c     = '0;
        mem_req_c  = 1'b0;
        valid_c    = 1'b0;
        halted_c   = 1'b0;
        latch_c    = 1'b0;
        push_c     = 1'b0;
        pop_c      = 1'b0;
        set_ovf_c  = 1'b0;
        set_unf_c  = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (start) next_state = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req_c = 1'b1;
                if (bus.mem_ack) begin
                    latch_c    = 1'b1;
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                valid_c = 1'b1;
                if (bus.instr_ready) begin
                    next_state = ST_FETCH;
                    unique case (act)
                        ACT_HALT: begin
                            next_state = ST_HALTED;
                        end
                        ACT_UNDERFLOW: begin
                            set_unf_c  = 1'b1;
                            next_state = ST_HALTED;
                        end
                        ACT_POP: begin
                            pop_c  = 1'b1;
                            sel_c  = PC_LOAD;
                            load_c = stack_top;
                        end
                        ACT_OVERFLOW: begin
                            set_ovf_c  = 1'b1;
                            next_state = ST_HALTED;
                        end
                        ACT_PUSH: begin
                            push_c = 1'b1;
                            sel_c  = PC_LOAD;
                            load_c = bus.branch_target;
                        end
                        ACT_BRANCH: begin
                            sel_c  = PC_LOAD;
                            load_c = bus.branch_target;
                        end
                        default: begin
                            sel_c = PC_NEXT;
                        end
                    endcase
                end
            end
            ST_HALTED: begin
                halted_c = 1'b1;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign pc_selector     = sel_c;
    assign pc_load_value   = load_c;
    assign halted          = halted_c;
    assign dbg_state       = state;

    assign bus.mem_req     = mem_req_c;
    assign bus.mem_addr    = pc_value;
    assign bus.instr_valid = valid_c;
    assign bus.instr_data  = instr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: driver tasks issue fetch/issue transactions,
// a negedge monitor checks them against expected queues.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam int WS = 15;
    localparam int DW = 16;
    localparam int SD = 4;

    localparam logic [3:0] C_NONE = 4'b0000;
    localparam logic [3:0] C_BR   = 4'b0001;
    localparam logic [3:0] C_CALL = 4'b0010;
    localparam logic [3:0] C_RET  = 4'b0100;
    localparam logic [3:0] C_HALT = 4'b1000;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [WS-1:0] pc_value;
    logic [1:0]    pc_selector;
    logic [WS-1:0] pc_load_value;
    logic          halted;
    logic          stack_overflow;
    logic          stack_underflow;
    seq_state_t    dbg_state;

    pc_sequencer_if #(.WORD_SIZE(WS), .DATA_WIDTH(DW)) bus ();

    pc_sequencer #(
        .WORD_SIZE   (WS),
        .DATA_WIDTH  (DW),
        .STACK_DEPTH (SD)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .pc_value        (pc_value),
        .pc_selector     (pc_selector),
        .pc_load_value   (pc_load_value),
        .bus             (bus),
        .halted          (halted),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    // ProgramCounter model, reset together with the sequencer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_value <= '0;
        end else begin
            case (pc_selector)
                2'd0:    pc_value <= pc_value + WS'(1);
                2'd2:    pc_value <= pc_load_value;
                default: pc_value <= pc_value;
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    sel;
        logic [WS-1:0] load;
    } issue_t;

    logic [WS-1:0] exp_fetch_q[$];
    issue_t        exp_issue_q[$];
    issue_t        mon_e;
    int            n_cmp = 0;
    int            n_err = 0;

    function automatic logic [DW-1:0] mem_word(input logic [WS-1:0] a);
        return {1'b0, a} ^ 16'h5A3C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (bus.mem_req && bus.mem_ack) begin
                if (exp_fetch_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_fetch: got addr %0h, required no fetch", bus.mem_addr);
                end else begin
                    check("fetch_addr", 32'(bus.mem_addr), 32'(exp_fetch_q.pop_front()));
                end
            end
            if (bus.instr_valid) begin
                if (exp_issue_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_issue: got data %0h, required no issue", bus.instr_data);
                end else if (bus.instr_ready) begin
                    mon_e = exp_issue_q.pop_front();
                    check("issue_data", 32'(bus.instr_data), 32'(mon_e.data));
                    check("issue_sel", 32'(pc_selector), 32'(mon_e.sel));
                    check("issue_load", 32'(pc_load_value), 32'(mon_e.load));
                end else begin
                    check("hold_data", 32'(bus.instr_data), 32'(exp_issue_q[0].data));
                    check("hold_sel", 32'(pc_selector), 32'(PC_KEEP));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        start              = 1'b0;
        bus.mem_ack        = 1'b0;
        bus.mem_data       = '0;
        bus.instr_ready    = 1'b0;
        bus.branch_taken   = 1'b0;
        bus.branch_target  = '0;
        bus.call           = 1'b0;
        bus.ret            = 1'b0;
        bus.halt           = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_sel", 32'(pc_selector), 32'(PC_KEEP));
        check("rst_load", 32'(pc_load_value), 32'd0);
        check("rst_ovf", 32'(stack_overflow), 32'd0);
        check("rst_unf", 32'(stack_underflow), 32'd0);
        check("rst_instr", 32'(bus.instr_data), 32'd0);
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_state", 32'(dbg_state), 32'(ST_FETCH));
    endtask

    // One fetch + issue. Call at #1 after an edge with the DUT in FETCH.
    task automatic do_instr(input logic [WS-1:0] addr, input int ack_dly, input int rdy_dly,
                            input logic [3:0] ctl, input logic [WS-1:0] tgt,
                            input logic [1:0] exp_sel, input logic [WS-1:0] exp_load);
        exp_fetch_q.push_back(addr);
        exp_issue_q.push_back({mem_word(addr), exp_sel, exp_load});
        for (int i = 0; i < ack_dly; i++) begin
            bus.mem_ack  = 1'b0;
            bus.mem_data = DW'($urandom);
            #1;
            check("fetch_wait_req", 32'(bus.mem_req), 32'd1);
            check("fetch_wait_sel", 32'(pc_selector), 32'(PC_KEEP));
            tick();
        end
        bus.mem_ack  = 1'b1;
        bus.mem_data = mem_word(addr);
        tick();
        bus.mem_ack  = 1'b0;
        bus.mem_data = DW'($urandom);
        {bus.halt, bus.ret, bus.call, bus.branch_taken} = ctl;
        bus.branch_target = tgt;
        for (int i = 0; i < rdy_dly; i++) begin
            bus.instr_ready = 1'b0;
            bus.mem_data    = DW'($urandom);
            tick();
        end
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        {bus.halt, bus.ret, bus.call, bus.branch_taken} = 4'b0000;
        bus.branch_target = WS'($urandom);
    endtask

    task automatic check_halt(input logic ovf, input logic unf, input logic [WS-1:0] pc);
        check("halt_state", 32'(dbg_state), 32'(ST_HALTED));
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_ovf", 32'(stack_overflow), 32'(ovf));
        check("halt_unf", 32'(stack_underflow), 32'(unf));
        check("halt_sel", 32'(pc_selector), 32'(PC_KEEP));
        check("halt_pc", 32'(pc_value), 32'(pc));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        clear_inputs();
        tick();
        apply_reset();

        // Sequential run, immediate handshakes: 2 cycles per instruction.
        start_run();
        for (int i = 0; i < 4; i++) begin
            do_instr(WS'(i), 0, 0, C_NONE, '0, PC_NEXT, '0);
        end

        // Delayed ack and ready.
        do_instr(15'd4, 3, 2, C_NONE, '0, PC_NEXT, '0);

        // call / ret pair; controls held through ready wait must not act early.
        do_instr(15'd5, 0, 1, C_CALL, 15'h0100, PC_LOAD, 15'h0100);
        do_instr(15'h0100, 1, 0, C_RET, '0, PC_LOAD, 15'd6);

        // Fill the stack, pop once, refill, then overflow.
        do_instr(15'd6, 0, 0, C_CALL, 15'h0010, PC_LOAD, 15'h0010);
        do_instr(15'h0010, 0, 0, C_CALL, 15'h0020, PC_LOAD, 15'h0020);
        do_instr(15'h0020, 0, 0, C_CALL, 15'h0030, PC_LOAD, 15'h0030);
        do_instr(15'h0030, 0, 0, C_CALL, 15'h0040, PC_LOAD, 15'h0040);
        do_instr(15'h0040, 0, 0, C_RET, '0, PC_LOAD, 15'h0031);
        do_instr(15'h0031, 0, 0, C_CALL | C_BR, 15'h0050, PC_LOAD, 15'h0050);
        do_instr(15'h0050, 0, 0, C_CALL, 15'h0060, PC_KEEP, '0);
        check_halt(1'b1, 1'b0, 15'h0050);

        // HALTED ignores everything.
        start            = 1'b1;
        bus.mem_ack      = 1'b1;
        bus.instr_ready  = 1'b1;
        bus.branch_taken = 1'b1;
        bus.branch_target = 15'h1111;
        tick();
        tick();
        tick();
        clear_inputs();
        check_halt(1'b1, 1'b0, 15'h0050);

        // ret with empty stack.
        apply_reset();
        start_run();
        do_instr(15'd0, 0, 0, C_RET | C_CALL, 15'h0222, PC_KEEP, '0);
        check_halt(1'b0, 1'b1, 15'd0);

        // halt beats branch.
        apply_reset();
        start_run();
        do_instr(15'd0, 1, 1, C_HALT | C_BR, 15'h1234, PC_KEEP, '0);
        check_halt(1'b0, 1'b0, 15'd0);

        // Address wrap, and a return address that wraps to 0.
        apply_reset();
        start_run();
        do_instr(15'd0, 0, 0, C_BR, 15'h7FFF, PC_LOAD, 15'h7FFF);
        do_instr(15'h7FFF, 0, 0, C_NONE, '0, PC_NEXT, '0);
        do_instr(15'd0, 0, 0, C_BR, 15'h7FFF, PC_LOAD, 15'h7FFF);
        do_instr(15'h7FFF, 0, 0, C_CALL, 15'h0200, PC_LOAD, 15'h0200);
        do_instr(15'h0200, 0, 0, C_NONE, '0, PC_NEXT, '0);
        do_instr(15'h0201, 0, 0, C_RET | C_BR, 15'h0555, PC_LOAD, 15'd0);
        do_instr(15'd0, 0, 0, C_HALT, '0, PC_KEEP, '0);
        check_halt(1'b0, 1'b0, 15'd0);

        // Asynchronous reset in the middle of a fetch.
        apply_reset();
        start_run();
        do_instr(15'd0, 0, 0, C_NONE, '0, PC_NEXT, '0);
        bus.mem_ack = 1'b0;
        tick();
        #2;
        check("midfetch_req_before", 32'(bus.mem_req), 32'd1);
        reset = 1'b0;
        #1;
        check("midfetch_req", 32'(bus.mem_req), 32'd0);
        check("midfetch_state", 32'(dbg_state), 32'(ST_IDLE));
        check("midfetch_pc", 32'(pc_value), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        start_run();
        do_instr(15'd0, 0, 0, C_NONE, '0, PC_NEXT, '0);
        do_instr(15'd1, 0, 0, C_HALT, '0, PC_KEEP, '0);
        check_halt(1'b0, 1'b0, 15'd1);

        tick();
        check("fetch_q_drained", 32'(exp_fetch_q.size()), 32'd0);
        check("issue_q_drained", 32'(exp_issue_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Fetch/issue controller that drives the ProgramCounter `selector` and `instruction` (load value) inputs.
- Runs a fetch handshake with instruction memory and presents fetched words to the decoder with a valid/ready handshake.
- Resolves branch, call, return and halt requests from the decoder; call/return use a small return-address stack.
- Sits between the ProgramCounter, instruction memory and decoder in the processor top level.

Parameters:
- WORD_SIZE, 15, width of the PC / instruction address.
- DATA_WIDTH, 16, width of the fetched instruction word.
- STACK_DEPTH, 4, return-address stack entries (>=1).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin execution; sampled only in IDLE.
- pc_value  in  WORD_SIZE  current ProgramCounter `out`.
- pc_selector  out  2  to ProgramCounter: 0=NEXT, 1=KEEP, 2=LOAD.
- pc_load_value  out  WORD_SIZE  to ProgramCounter `instruction`; 0 unless pc_selector=LOAD.
- mem_req  out  1  fetch request; address is mem_addr.
- mem_addr  out  WORD_SIZE  equals pc_value.
- mem_ack  in  1  fetch data valid on mem_data; ignored outside FETCH.
- mem_data  in  DATA_WIDTH  fetched instruction word.
- instr_valid  out  1  instr_data is valid for the decoder.
- instr_data  out  DATA_WIDTH  latched instruction word.
- instr_ready  in  1  decoder accepts; control inputs are sampled with it.
- branch_taken  in  1  load branch_target.
- branch_target  in  WORD_SIZE  target for branch or call.
- call  in  1  push pc_value+1, then load branch_target.
- ret  in  1  pop the stack into the PC.
- halt  in  1  stop execution.
- halted  out  1  high in HALTED.
- stack_overflow  out  1  sticky; call attempted with the stack full.
- stack_underflow  out  1  sticky; ret attempted with the stack empty.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, stack empty, instr_data=0, both flags 0, mem_req=0, instr_valid=0, halted=0, pc_selector=KEEP, pc_load_value=0.
- The top level resets the ProgramCounter concurrently, so pc_value=0 on leaving reset.
- IDLE: pc_selector=KEEP. start=1 -> FETCH.
- FETCH:
  - mem_req=1, pc_selector=KEEP.
  - mem_ack=1 (allowed in the same cycle mem_req first rises): latch mem_data into instr_data -> ISSUE.
- ISSUE:
  - instr_valid=1.
  - instr_ready=0: pc_selector=KEEP, stay; instr_data stays stable.
  - instr_ready=1: resolve by priority halt > ret > call > branch_taken > sequential.
    - halt: KEEP -> HALTED.
    - ret, stack empty: set stack_underflow, KEEP -> HALTED.
    - ret, stack non-empty: pop, LOAD popped value -> FETCH.
    - call, stack full: set stack_overflow, KEEP -> HALTED.
    - call, stack not full: push (pc_value+1) mod 2^WORD_SIZE, LOAD branch_target -> FETCH.
    - branch_taken: LOAD branch_target -> FETCH.
    - none asserted: NEXT -> FETCH.
  - Lower-priority requests asserted alongside a higher one are ignored.
- HALTED: halted=1, KEEP, all inputs ignored; exit only via reset.
- Selector outputs are combinational from state and inputs. The PC updates on the edge leaving ISSUE, so FETCH always sees the new pc_value.
- Minimum throughput: 2 cycles per instruction (immediate mem_ack and instr_ready).
- Wrap-around: NEXT at 2^WORD_SIZE-1 relies on the PC wrapping to 0; a pushed return address of 2^WORD_SIZE-1 + 1 is stored as 0.
- start outside IDLE, and mem_ack outside FETCH, have no effect.
- Reset mid-fetch or mid-issue returns to IDLE immediately; stack contents are discarded.

Decomposition:
- Shared processor defines include: PC selector constants (NEXT=0, KEEP=1, LOAD=2) and the sequencer state encoding (IDLE, FETCH, ISSUE, HALTED).
- Sub-module return_address_stack:
  - Parameters WORD_SIZE and STACK_DEPTH.
  - Ports push, pop, push_data, top, full, empty.
  - Same clock and asynchronous active-low reset.

Test Plan:
- Reset, start, mem_ack and instr_ready immediate, no control inputs, 4 instructions -> pc_selector NEXT once per 2 cycles; pc_value 0,1,2,3 on successive FETCH.
- mem_ack delayed 3 cycles, instr_ready delayed 2 cycles -> mem_req held 3 cycles and instr_valid held 2 cycles with KEEP; instr_data stable throughout.
- At pc=5, call with target 0x0100, then ret -> LOAD 0x0100; next FETCH at 0x0100; after ret, LOAD 6.
- Five nested calls with STACK_DEPTH=4 -> fifth call sets stack_overflow, halted=1, pc held; ret at reset state -> stack_underflow=1, halted=1.
- halt+branch_taken asserted together -> HALTED, pc unchanged. Sequential run from pc=0x7FFF -> next FETCH at 0.
- reset=0 asserted mid-FETCH (mem_req=1), async between edges -> mem_req=0 immediately, state IDLE; start restarts fetch at pc 0.
